// File: rtl/pbs_result_display.sv
// -----------------------------------------------------------------------------
// pbs_result_display
//
// Buffers turn records coming out of the battle datapath. A user steps through
// the four fields of the oldest record with the go button. Each press/release
// advances one field. Releasing go on the last field retires the record.
//
// Parameters:
//   DEPTH          number of buffered records (power of two, >= 2)
//
// Ports:
//   clk            single clock, rising-edge
//   reset          asynchronous, active-high reset
//   go             step button level (1 = pressed)
//   rec_valid      a turn record is offered this cycle
//   rec_player_hp  player HP after the turn
//   rec_ai_hp      AI HP after the turn
//   rec_damage     damage applied this turn
//   rec_flags      bit1 = victory, bit0 = loss
//   rec_ready      buffer can accept a record (not full)
//   data_out       value of the displayed field, 0 when idle
//   field_sel      index of the displayed field
//   showing        a record is being displayed
//   done_pulse     one-cycle pulse when a record is retired
//   overflow       sticky: a record was offered while the buffer was full
// -----------------------------------------------------------------------------
module pbs_result_display #(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       rec_valid,
    input  logic [7:0] rec_player_hp,
    input  logic [7:0] rec_ai_hp,
    input  logic [7:0] rec_damage,
    input  logic [1:0] rec_flags,
    output logic       rec_ready,
    output logic [7:0] data_out,
    output logic [1:0] field_sel,
    output logic       showing,
    output logic       done_pulse,
    output logic       overflow
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_SHOW_WAIT
    } state_e;

    // Record layout: {flags, damage, ai_hp, player_hp}
    logic [25:0] mem_q [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    state_e          state_q, state_d;
    logic [1:0]      field_sel_q, field_sel_d;
    logic            done_pulse_q, done_pulse_d;
    logic            overflow_q, overflow_d;

    logic            push;
    logic            pop;
    logic [25:0]     rec_in;
    logic [25:0]     head_rec;

    // ---------------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------------

    // Full check looks only at the registered count: a pop in the same cycle
    // does not make room for a push.
    assign rec_ready = (count_q != CountFull);
    assign push      = rec_valid && rec_ready;
    assign rec_in    = {rec_flags, rec_damage, rec_ai_hp, rec_player_hp};
    assign head_rec  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        // DEPTH is a power of two, so the natural wrap of the pointer is modulo DEPTH.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (rec_valid && !rec_ready) begin
            overflow_d = 1'b1;
        end
    end

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rec_in;
        end
    end

    // ---------------------------------------------------------------------
    // Display stepping FSM
    // ---------------------------------------------------------------------

    always_comb begin
        state_d      = state_q;
        field_sel_d  = field_sel_q;
        done_pulse_d = 1'b0;
        pop          = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Wait for go low so that a held button cannot skip field 0.
                if ((count_q != '0) && !go) begin
                    state_d     = S_SHOW;
                    field_sel_d = 2'd0;
                end
            end
            S_SHOW: begin
                if (go) begin
                    state_d = S_SHOW_WAIT;
                end
            end
            S_SHOW_WAIT: begin
                // Advance on release.
                if (!go) begin
                    if (field_sel_q != 2'd3) begin
                        field_sel_d = field_sel_q + 2'd1;
                        state_d     = S_SHOW;
                    end else begin
                        pop          = 1'b1;
                        done_pulse_d = 1'b1;
                        field_sel_d  = 2'd0;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                field_sel_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            field_sel_q  <= 2'd0;
            done_pulse_q <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            field_sel_q  <= field_sel_d;
            done_pulse_q <= done_pulse_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------

    always_comb begin
        data_out = 8'd0;
        if (state_q != S_IDLE) begin
            unique case (field_sel_q)
                2'd0:    data_out = head_rec[7:0];
                2'd1:    data_out = head_rec[15:8];
                2'd2:    data_out = head_rec[23:16];
                default: data_out = {6'b0, head_rec[25:24]};
            endcase
        end
    end

    assign showing    = (state_q == S_SHOW) || (state_q == S_SHOW_WAIT);
    assign field_sel  = field_sel_q;
    assign done_pulse = done_pulse_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_pbs_result_display.sv
// -----------------------------------------------------------------------------
// tb_pbs_result_display
//
// Directed bench for pbs_result_display (DEPTH = 2). Inputs change and outputs
// are sampled on the falling clock edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_pbs_result_display;

    logic       clk;
    logic       reset;
    logic       go;
    logic       rec_valid;
    logic [7:0] rec_player_hp;
    logic [7:0] rec_ai_hp;
    logic [7:0] rec_damage;
    logic [1:0] rec_flags;
    logic       rec_ready;
    logic [7:0] data_out;
    logic [1:0] field_sel;
    logic       showing;
    logic       done_pulse;
    logic       overflow;

    int n_cmp;
    int n_bad;

    pbs_result_display #(
        .DEPTH(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .rec_valid    (rec_valid),
        .rec_player_hp(rec_player_hp),
        .rec_ai_hp    (rec_ai_hp),
        .rec_damage   (rec_damage),
        .rec_flags    (rec_flags),
        .rec_ready    (rec_ready),
        .data_out     (data_out),
        .field_sel    (field_sel),
        .showing      (showing),
        .done_pulse   (done_pulse),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers (no checking inside).
    task automatic do_reset();
        go = 1'b0;
        rec_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Offer one record for one cycle; returns at the falling edge after the push edge.
    task automatic push(input logic [7:0] hp, input logic [7:0] ai, input logic [7:0] dmg,
                        input logic [1:0] fl);
        rec_player_hp = hp;
        rec_ai_hp = ai;
        rec_damage = dmg;
        rec_flags = fl;
        rec_valid = 1'b1;
        @(negedge clk);
        rec_valid = 1'b0;
    endtask

    task automatic press();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        go = 1'b0;
        rec_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (showing !== 1'b0) begin n_bad++; $display("FAIL rst_showing got=%b exp=0", showing); end
        n_cmp++; if (data_out !== 8'd0) begin n_bad++; $display("FAIL rst_data got=%0d exp=0", data_out); end
        n_cmp++; if (rec_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b exp=1", rec_ready); end
        n_cmp++; if (field_sel !== 2'd0) begin n_bad++; $display("FAIL rst_field got=%0d exp=0", field_sel); end
        n_cmp++; if (done_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b exp=0", done_pulse); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_reset();
        push(8'd100, 8'd80, 8'd20, 2'b00);
        n_cmp++; if (showing !== 1'b0) begin n_bad++; $display("FAIL basic_lat1 showing got=%b exp=0", showing); end
        @(negedge clk);
        n_cmp++; if (showing !== 1'b1) begin n_bad++; $display("FAIL basic_lat2 showing got=%b exp=1", showing); end
        n_cmp++; if (field_sel !== 2'd0) begin n_bad++; $display("FAIL basic_f0 field got=%0d exp=0", field_sel); end
        n_cmp++; if (data_out !== 8'd100) begin n_bad++; $display("FAIL basic_f0 data got=%0d exp=100", data_out); end
        press();
        n_cmp++; if (field_sel !== 2'd1) begin n_bad++; $display("FAIL basic_f1 field got=%0d exp=1", field_sel); end
        n_cmp++; if (data_out !== 8'd80) begin n_bad++; $display("FAIL basic_f1 data got=%0d exp=80", data_out); end
        press();
        n_cmp++; if (data_out !== 8'd20) begin n_bad++; $display("FAIL basic_f2 data got=%0d exp=20", data_out); end
        press();
        n_cmp++; if (field_sel !== 2'd3) begin n_bad++; $display("FAIL basic_f3 field got=%0d exp=3", field_sel); end
        n_cmp++; if (data_out !== 8'd0) begin n_bad++; $display("FAIL basic_f3 data got=%0d exp=0", data_out); end
        n_cmp++; if (done_pulse !== 1'b0) begin n_bad++; $display("FAIL basic_early_done got=%b exp=0", done_pulse); end
        press();
        n_cmp++; if (done_pulse !== 1'b1) begin n_bad++; $display("FAIL basic_done got=%b exp=1", done_pulse); end
        n_cmp++; if (showing !== 1'b0) begin n_bad++; $display("FAIL basic_after showing got=%b exp=0", showing); end
        n_cmp++; if (data_out !== 8'd0) begin n_bad++; $display("FAIL basic_after data got=%0d exp=0", data_out); end
        @(negedge clk);
        n_cmp++; if (done_pulse !== 1'b0) begin n_bad++; $display("FAIL basic_done_once got=%b exp=0", done_pulse); end
        n_cmp++; if (showing !== 1'b0) begin n_bad++; $display("FAIL basic_empty showing got=%b exp=0", showing); end
    endtask

    task automatic test_overflow();
        do_reset();
        push(8'd11, 8'd12, 8'd13, 2'b01);
        push(8'd21, 8'd22, 8'd23, 2'b10);
        n_cmp++; if (rec_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_full_ready got=%b exp=0", rec_ready); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_pre got=%b exp=0", overflow); end
        push(8'd31, 8'd32, 8'd33, 2'b11);
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        n_cmp++; if (data_out !== 8'd11) begin n_bad++; $display("FAIL ovf_head got=%0d exp=11", data_out); end
        press();
        n_cmp++; if (data_out !== 8'd12) begin n_bad++; $display("FAIL ovf_a1 got=%0d exp=12", data_out); end
        press();
        n_cmp++; if (data_out !== 8'd13) begin n_bad++; $display("FAIL ovf_a2 got=%0d exp=13", data_out); end
        press();
        n_cmp++; if (data_out !== 8'd1) begin n_bad++; $display("FAIL ovf_a3 got=%0d exp=1", data_out); end
        press();
        n_cmp++; if (done_pulse !== 1'b1) begin n_bad++; $display("FAIL ovf_done_a got=%b exp=1", done_pulse); end
        @(negedge clk);
        n_cmp++; if (showing !== 1'b1) begin n_bad++; $display("FAIL ovf_b_start got=%b exp=1", showing); end
        n_cmp++; if (data_out !== 8'd21) begin n_bad++; $display("FAIL ovf_b0 got=%0d exp=21", data_out); end
        press();
        press();
        n_cmp++; if (data_out !== 8'd23) begin n_bad++; $display("FAIL ovf_b2 got=%0d exp=23", data_out); end
        press();
        press();
        n_cmp++; if (done_pulse !== 1'b1) begin n_bad++; $display("FAIL ovf_done_b got=%b exp=1", done_pulse); end
        repeat (3) @(negedge clk);
        n_cmp++; if (showing !== 1'b0) begin n_bad++; $display("FAIL ovf_third_dropped got=%b exp=0", showing); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        n_cmp++; if (rec_ready !== 1'b1) begin n_bad++; $display("FAIL ovf_ready_back got=%b exp=1", rec_ready); end
    endtask

    task automatic test_held_go();
        do_reset();
        go = 1'b1;
        push(8'd55, 8'd66, 8'd77, 2'b00);
        repeat (3) @(negedge clk);
        n_cmp++; if (showing !== 1'b0) begin n_bad++; $display("FAIL held_idle got=%b exp=0", showing); end
        go = 1'b0;
        @(negedge clk);
        n_cmp++; if (showing !== 1'b1) begin n_bad++; $display("FAIL held_show got=%b exp=1", showing); end
        repeat (2) @(negedge clk);
        n_cmp++; if (field_sel !== 2'd0) begin n_bad++; $display("FAIL held_field got=%0d exp=0", field_sel); end
        n_cmp++; if (data_out !== 8'd55) begin n_bad++; $display("FAIL held_data got=%0d exp=55", data_out); end
        press();
        n_cmp++; if (data_out !== 8'd66) begin n_bad++; $display("FAIL held_next got=%0d exp=66", data_out); end
    endtask

    task automatic test_full_pop();
        do_reset();
        push(8'd1, 8'd2, 8'd3, 2'b00);
        push(8'd4, 8'd5, 8'd6, 2'b00);
        press();
        press();
        press();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        rec_player_hp = 8'd9;
        rec_ai_hp = 8'd9;
        rec_damage = 8'd9;
        rec_flags = 2'b11;
        rec_valid = 1'b1;
        n_cmp++; if (rec_ready !== 1'b0) begin n_bad++; $display("FAIL fp_ready got=%b exp=0", rec_ready); end
        @(negedge clk);
        rec_valid = 1'b0;
        n_cmp++; if (done_pulse !== 1'b1) begin n_bad++; $display("FAIL fp_done got=%b exp=1", done_pulse); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fp_ovf got=%b exp=1", overflow); end
        n_cmp++; if (rec_ready !== 1'b1) begin n_bad++; $display("FAIL fp_count1 got=%b exp=1", rec_ready); end
        @(negedge clk);
        n_cmp++; if (data_out !== 8'd4) begin n_bad++; $display("FAIL fp_next got=%0d exp=4", data_out); end
        press();
        press();
        press();
        press();
        repeat (3) @(negedge clk);
        n_cmp++; if (showing !== 1'b0) begin n_bad++; $display("FAIL fp_empty got=%b exp=0", showing); end
    endtask

    task automatic test_flags();
        do_reset();
        push(8'd7, 8'd8, 8'd200, 2'b10);
        @(negedge clk);
        press();
        press();
        n_cmp++; if (data_out !== 8'd200) begin n_bad++; $display("FAIL flags_dmg got=%0d exp=200", data_out); end
        press();
        n_cmp++; if (data_out !== 8'h02) begin n_bad++; $display("FAIL flags_f3 got=%0h exp=02", data_out); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(8'd40, 8'd41, 8'd42, 2'b00);
        @(negedge clk);
        press();
        press();
        press();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        rec_player_hp = 8'd90;
        rec_ai_hp = 8'd91;
        rec_damage = 8'd92;
        rec_flags = 2'b01;
        rec_valid = 1'b1;
        @(negedge clk);
        rec_valid = 1'b0;
        n_cmp++; if (done_pulse !== 1'b1) begin n_bad++; $display("FAIL b2b_done got=%b exp=1", done_pulse); end
        n_cmp++; if (showing !== 1'b0) begin n_bad++; $display("FAIL b2b_gap got=%b exp=0", showing); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf got=%b exp=0", overflow); end
        @(negedge clk);
        n_cmp++; if (showing !== 1'b1) begin n_bad++; $display("FAIL b2b_restart got=%b exp=1", showing); end
        n_cmp++; if (data_out !== 8'd90) begin n_bad++; $display("FAIL b2b_data got=%0d exp=90", data_out); end
        press();
        press();
        press();
        press();
        repeat (3) @(negedge clk);
        n_cmp++; if (showing !== 1'b0) begin n_bad++; $display("FAIL b2b_count got=%b exp=0", showing); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(8'd1, 8'd2, 8'd3, 2'b00);
        push(8'd4, 8'd5, 8'd6, 2'b00);
        press();
        press();
        go = 1'b1;
        @(negedge clk);
        n_cmp++; if (field_sel !== 2'd2) begin n_bad++; $display("FAIL rm_field got=%0d exp=2", field_sel); end
        reset = 1'b1;
        #1;
        n_cmp++; if (showing !== 1'b0) begin n_bad++; $display("FAIL rm_showing got=%b exp=0", showing); end
        n_cmp++; if (data_out !== 8'd0) begin n_bad++; $display("FAIL rm_data got=%0d exp=0", data_out); end
        n_cmp++; if (rec_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready got=%b exp=1", rec_ready); end
        n_cmp++; if (done_pulse !== 1'b0) begin n_bad++; $display("FAIL rm_done got=%b exp=0", done_pulse); end
        go = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (done_pulse !== 1'b0 || showing !== 1'b0) begin
                n_bad++;
                $display("FAIL rm_after%0d done=%b showing=%b exp=0/0", i, done_pulse, showing);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        go = 1'b0;
        rec_valid = 1'b0;
        rec_player_hp = 8'd0;
        rec_ai_hp = 8'd0;
        rec_damage = 8'd0;
        rec_flags = 2'b00;
        test_reset();
        test_basic();
        test_overflow();
        test_held_go();
        test_full_pop();
        test_flags();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
